// File: rtl/seg_frame_decoder.sv
// Reassembles a frame of active-low 7-segment digits into a BCD word, flagging illegal patterns.
// Digits arrive MSD first; a partial frame is dropped if the gap between digits runs too long.
module seg_frame_decoder #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic                    seg_valid,
    output logic                    seg_ready,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    out_valid,
    output logic                    frame_abort
);

    localparam int unsigned BW = 4 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StCollect, StPublish} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [BW-1:0]         stage_bcd_q, stage_bcd_d, bcd_q, bcd_d, nib_ext;
    logic [NUM_DIGITS-1:0] stage_err_q, stage_err_d, err_q, err_d, err_ext;
    logic                  abort_q, abort_d;
    logic [3:0]            nib;
    logic                  bad;
    logic                  accept, last;

    always_comb begin
        nib = 4'hE;
        bad = 1'b1;
        case (seg_in)
            7'b1000000: begin nib = 4'h0; bad = 1'b0; end
            7'b1111001: begin nib = 4'h1; bad = 1'b0; end
            7'b0100100: begin nib = 4'h2; bad = 1'b0; end
            7'b0110000: begin nib = 4'h3; bad = 1'b0; end
            7'b0011001: begin nib = 4'h4; bad = 1'b0; end
            7'b0010010: begin nib = 4'h5; bad = 1'b0; end
            7'b0000010: begin nib = 4'h6; bad = 1'b0; end
            7'b1111000: begin nib = 4'h7; bad = 1'b0; end
            7'b0000000: begin nib = 4'h8; bad = 1'b0; end
            7'b0011000: begin nib = 4'h9; bad = 1'b0; end
            7'b1111111: begin nib = 4'hF; bad = 1'b0; end
            default:    begin nib = 4'hE; bad = 1'b1; end
        endcase
    end

    always_comb begin
        nib_ext      = '0;
        nib_ext[3:0] = nib;
        err_ext      = '0;
        err_ext[0]   = bad;
    end

    // Ready and the pulses are forced low while reset is held, even before state is cleared.
    assign seg_ready   = !reset && (state_q != StPublish);
    assign out_valid   = !reset && (state_q == StPublish);
    assign frame_abort = !reset && abort_q;
    assign accept      = seg_valid && seg_ready;
    assign last        = accept && (count_q == CW'(NUM_DIGITS - 1));
    assign bcd_out     = bcd_q;
    assign digit_err   = err_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tcnt_d      = '0;
        stage_bcd_d = stage_bcd_q;
        stage_err_d = stage_err_q;
        bcd_d       = bcd_q;
        err_d       = err_q;
        abort_d     = 1'b0;

        if (accept) begin
            if (state_q == StIdle) begin
                stage_bcd_d = nib_ext;
                stage_err_d = err_ext;
            end else begin
                stage_bcd_d = (stage_bcd_q << 4) | nib_ext;
                stage_err_d = (stage_err_q << 1) | err_ext;
            end
        end

        unique case (state_q)
            StIdle, StCollect: begin
                if (accept) begin
                    count_d = count_q + CW'(1);
                    state_d = StCollect;
                end else if (state_q == StCollect) begin
                    if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        state_d     = StIdle;
                        count_d     = '0;
                        stage_bcd_d = '0;
                        stage_err_d = '0;
                        abort_d     = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                // Outputs load on the final accept so they are already visible while out_valid is high.
                if (last) begin
                    state_d = StPublish;
                    count_d = '0;
                    bcd_d   = stage_bcd_d;
                    err_d   = stage_err_d;
                end
            end
            StPublish: begin
                state_d = StIdle;
                count_d = '0;
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            tcnt_q      <= '0;
            stage_bcd_q <= '0;
            stage_err_q <= '0;
            bcd_q       <= '0;
            err_q       <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tcnt_q      <= tcnt_d;
            stage_bcd_q <= stage_bcd_d;
            stage_err_q <= stage_err_d;
            bcd_q       <= bcd_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
        end
    end

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Self-checking bench for seg_frame_decoder: fixed frame table, corner-case sequences and random
// traffic, all checked every cycle against a queue-based frame model.
module tb_seg_frame_decoder;

    localparam int unsigned N = 4;
    localparam int unsigned T = 16;

    localparam logic [6:0] PAT [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0011000};
    localparam logic [6:0] BLANK = 7'b1111111;

    logic            CLOCK_50 = 1'b0;
    logic            reset = 1'b1;
    logic [6:0]      seg_in = '0;
    logic            seg_valid = 1'b0;
    logic            seg_ready;
    logic [4*N-1:0]  bcd_out;
    logic [N-1:0]    digit_err;
    logic            out_valid;
    logic            frame_abort;

    seg_frame_decoder #(.NUM_DIGITS(N), .TIMEOUT(T)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .bcd_out    (bcd_out),
        .digit_err  (digit_err),
        .out_valid  (out_valid),
        .frame_abort(frame_abort)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of decoded digits for the frame in progress.
    int          q_nib[$];
    int          q_err[$];
    int          idle = 0;
    bit          pub = 0;
    bit          abort_nx = 0;
    logic [15:0] m_bcd = '0;
    logic [3:0]  m_err = '0;

    // Snapshots of the DUT taken in the most recent step.
    logic        s_rdy, s_ov, s_ab;
    logic [15:0] s_bcd;
    logic [3:0]  s_err;
    bit          s_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void decode(input logic [6:0] s, output int nib, output int err);
        nib = 14;
        err = 1;
        if (s == BLANK) begin
            nib = 15;
            err = 0;
        end
        for (int i = 0; i < 10; i++) begin
            if (s == PAT[i]) begin
                nib = i;
                err = 0;
            end
        end
    endfunction

    task automatic step(input bit v, input logic [6:0] s, input bit r);
        bit exp_rdy;
        int nb, er;
        @(negedge CLOCK_50);
        seg_valid = v;
        seg_in    = v ? s : 7'bx;
        reset     = r;
        #1;
        exp_rdy = !r && !pub;
        s_rdy = seg_ready;
        s_ov  = out_valid;
        s_ab  = frame_abort;
        s_bcd = bcd_out;
        s_err = digit_err;
        chk("seg_ready", 32'(seg_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(!r && pub));
        chk("frame_abort", 32'(frame_abort), 32'(!r && abort_nx));
        if (!r) begin
            chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
            chk("digit_err", 32'(digit_err), 32'(m_err));
        end
        s_acc = v && exp_rdy;
        @(posedge CLOCK_50);
        if (r) begin
            q_nib.delete();
            q_err.delete();
            idle = 0; pub = 0; abort_nx = 0; m_bcd = '0; m_err = '0;
        end else begin
            pub = 0;
            abort_nx = 0;
            if (s_acc) begin
                decode(s, nb, er);
                q_nib.push_back(nb);
                q_err.push_back(er);
                idle = 0;
                if (q_nib.size() == N) begin
                    m_bcd = '0;
                    m_err = '0;
                    for (int i = 0; i < N; i++) begin
                        m_bcd = (m_bcd << 4) | 16'(q_nib[i]);
                        m_err = (m_err << 1) | 4'(q_err[i]);
                    end
                    pub = 1;
                    q_nib.delete();
                    q_err.delete();
                end
            end else if (q_nib.size() > 0) begin
                idle++;
                if (idle == T) begin
                    abort_nx = 1;
                    idle = 0;
                    q_nib.delete();
                    q_err.delete();
                end
            end
        end
    endtask

    typedef struct {
        logic [6:0]  seg [4];
        logic [15:0] bcd;
        logic [3:0]  err;
    } vec_t;

    vec_t vecs [4];
    int   n_ab;
    int   idx;
    logic [15:0] got[$];

    initial begin
        vecs[0] = '{seg: '{BLANK, PAT[0], 7'b0101010, PAT[7]}, bcd: 16'hF0E7, err: 4'b0010};
        vecs[1] = '{seg: '{PAT[6], PAT[1], PAT[4], PAT[5]}, bcd: 16'h6145, err: 4'b0000};
        vecs[2] = '{seg: '{PAT[8], 7'b0000001, PAT[2], 7'b1110111}, bcd: 16'h8E2E, err: 4'b0101};
        vecs[3] = '{seg: '{PAT[6], PAT[1], PAT[4], PAT[5]}, bcd: 16'h6145, err: 4'b0000};

        step(0, '0, 1);
        step(0, '0, 1);
        step(0, '0, 0);
        chk("reset bcd_out", 32'(s_bcd), 32'h0);
        chk("reset digit_err", 32'(s_err), 32'h0);
        chk("reset seg_ready", 32'(s_rdy), 32'h1);

        // Table frames, back to back digits; the publish cycle is the step after the last digit.
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 4; d++) step(1, vecs[k].seg[d], 0);
            step(0, '0, 0);
            chk("tbl out_valid", 32'(s_ov), 32'h1);
            chk("tbl seg_ready", 32'(s_rdy), 32'h0);
            chk("tbl bcd_out", 32'(s_bcd), 32'(vecs[k].bcd));
            chk("tbl digit_err", 32'(s_err), 32'(vecs[k].err));
            step(0, '0, 0);
            chk("tbl single pulse", 32'(s_ov), 32'h0);
        end

        // Timeout: two digits then a long gap.
        step(1, PAT[3], 0);
        step(1, PAT[3], 0);
        n_ab = 0;
        for (int i = 0; i < T + 3; i++) begin
            step(0, '0, 0);
            if (s_ab) n_ab++;
            if (i < T) chk("no early abort", 32'(s_ab), 32'h0);
        end
        chk("abort count", 32'(n_ab), 32'd1);
        chk("bcd kept after abort", 32'(s_bcd), 32'h6145);
        for (int d = 1; d <= 4; d++) step(1, PAT[d], 0);
        step(0, '0, 0);
        chk("fresh frame", 32'(s_bcd), 32'h1234);
        chk("fresh frame valid", 32'(s_ov), 32'h1);

        // seg_valid held high across publish cycles.
        idx = 0;
        got.delete();
        for (int i = 0; i < 20 && idx < 8; i++) begin
            step(1, PAT[idx], 0);
            if (s_ov) got.push_back(s_bcd);
            if (s_acc) idx++;
        end
        step(0, '0, 0);
        if (s_ov) got.push_back(s_bcd);
        chk("stream digits", 32'(idx), 32'd8);
        chk("stream frames", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("stream frame0", 32'(got[0]), 32'h0123);
            chk("stream frame1", 32'(got[1]), 32'h4567);
        end

        // Reset mid-frame.
        for (int d = 0; d < 3; d++) step(1, PAT[7], 0);
        step(0, '0, 1);
        step(0, '0, 0);
        chk("midreset bcd", 32'(s_bcd), 32'h0);
        chk("midreset pulses", 32'({s_ov, s_ab}), 32'h0);
        for (int d = 0; d < 4; d++) step(1, PAT[9], 0);
        step(0, '0, 0);
        chk("after reset frame", 32'(s_bcd), 32'h9999);

        // Accept on the final permitted idle cycle.
        n_ab = 0;
        step(1, PAT[5], 0);
        for (int i = 0; i < T - 1; i++) begin
            step(0, '0, 0);
            if (s_ab) n_ab++;
        end
        for (int d = 6; d <= 8; d++) begin
            step(1, PAT[d], 0);
            if (s_ab) n_ab++;
        end
        step(0, '0, 0);
        if (s_ab) n_ab++;
        chk("late accept no abort", 32'(n_ab), 32'd0);
        chk("late accept bcd", 32'(s_bcd), 32'h5678);
        chk("late accept valid", 32'(s_ov), 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [6:0] s;
            sel = int'($urandom_range(0, 99));
            if (sel < 70) s = PAT[$urandom_range(0, 9)];
            else if (sel < 80) s = BLANK;
            else s = 7'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                step(0, '0, 1);
            end else if ($urandom_range(0, 29) == 0) begin
                int gap;
                gap = int'($urandom_range(T - 2, T + 2));
                for (int g = 0; g < gap; g++) step(0, '0, 0);
            end else begin
                step($urandom_range(0, 3) != 0, s, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_frame_decoder.md
Name: seg_frame_decoder

Overview:
- Inverse of the team's digit-to-7-segment encoder. Receives a frame of NUM_DIGITS active-low 7-segment patterns, one digit per handshake, most significant digit first (HEX3 first for NUM_DIGITS=4).
- Decodes each pattern back to a BCD nibble and flags any pattern that is not a legal digit.
- Publishes the assembled BCD word with a one-cycle valid pulse.
- Used to read back and self-check the display path, and for the board loopback test.

Parameters:
- NUM_DIGITS, 4: digits per frame; range 1..8.
- TIMEOUT, 1000: maximum idle cycles allowed between digits inside a frame before the frame is aborted; must be >= 2.

Ports:
- CLOCK_50  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- seg_in  input  7  segment pattern, active-low; bit0=a … bit6=g (digit 0 = 7'b1000000).
- seg_valid  input  1  seg_in holds a digit.
- seg_ready  output  1  block can accept a digit this cycle.
- bcd_out  output  4*NUM_DIGITS  decoded frame; first-received digit in the top nibble.
- digit_err  output  NUM_DIGITS  per-digit illegal-pattern flag; bit order matches the bcd_out nibbles.
- out_valid  output  1  one-cycle pulse when bcd_out and digit_err update.
- frame_abort  output  1  one-cycle pulse when a partial frame is discarded on timeout.

Behaviour:
- Reset values: bcd_out=0, digit_err=0, out_valid=0, frame_abort=0, seg_ready=0 during the reset cycle. After reset the FSM is in IDLE, digit count=0, timeout counter=0.
- Accept: a digit is accepted on a cycle where seg_valid && seg_ready.
  - seg_ready=1 in IDLE and COLLECT.
  - seg_ready=0 in PUBLISH.
- Decode happens at acceptance time. The nibble and error bit shift into internal staging registers; the staging order puts the first digit in the MSB position.
- Decode table (seg_in -> nibble):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9
  - 1111111 (blank) -> 4'hF, err=0.
  - Any other pattern -> 4'hE, err=1.
- FSM:
  - IDLE: on accept, store the digit and set count=1. Go to PUBLISH if NUM_DIGITS==1, else COLLECT.
  - COLLECT: on accept, store the digit, count++, clear the timeout counter. When the accepted digit is number NUM_DIGITS, go to PUBLISH. With no accept, increment the timeout counter.
  - COLLECT timeout: if the timeout counter reaches TIMEOUT-1 with no accept, go to IDLE, discard the staging registers, pulse frame_abort for 1 cycle. bcd_out and digit_err are left unchanged.
  - PUBLISH (exactly 1 cycle): load bcd_out and digit_err from staging, out_valid=1, seg_ready=0, clear count and timeout counter, then go to IDLE.
- Latency: out_valid asserts in the cycle after the last digit is accepted.
- Throughput: one frame per NUM_DIGITS+1 cycles minimum.
- Output hold: bcd_out and digit_err hold their values until the next PUBLISH or reset.
- Timeout counter is only active in COLLECT; it is held at 0 in IDLE and PUBLISH.
- Simultaneous accept and timeout threshold in the same cycle: the accept wins, no abort.
- seg_valid held high during PUBLISH: nothing is accepted. The same digit is accepted in the following IDLE cycle as the first digit of the next frame.
- seg_in is ignored when seg_valid=0 (X-tolerant).
- Reset mid-frame: the partial frame is discarded, no out_valid and no frame_abort. Outputs go to their reset values.
- out_valid and frame_abort are never high in the same cycle.

Test Plan:
- Frame 0000010,1111001,0011001,0010010 on 4 consecutive cycles -> out_valid one cycle after the 4th accept, bcd_out=16'h6145, digit_err=4'b0000, seg_ready=0 in that cycle.
- Frame 1111111,1000000,0101010,1111000 -> bcd_out=16'hF0E7, digit_err=4'b0010, out_valid pulses once.
- Two digits, then seg_valid=0 for TIMEOUT cycles -> frame_abort pulses once, bcd_out keeps its previous value (16'h6145), the next 4 digits decode as a fresh frame.
- seg_valid held high continuously with 8 digits 0..7 -> two frames: 16'h0123, then 16'h4567. A digit presented during each PUBLISH cycle is not lost; it becomes the first digit of the next frame.
- reset asserted after 3 digits accepted -> all outputs 0, no pulses; the next 4 digits (9,9,9,9 = 0011000) give bcd_out=16'h9999.
- Last permitted accept on the TIMEOUT-1 idle cycle -> no abort, frame completes normally.
